// File: rtl/button_sync_bank.sv
// Bank of N independent button conditioners: a synchroniser chain, a debounce
// filter and a press / auto-repeat pulse FSM per channel.
module button_sync_bank #(
    parameter int N            = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 8
) (
    input  logic         Clk,
    input  logic         ResetN,
    input  logic [N-1:0] Bi,
    input  logic [N-1:0] RepeatEn,
    output logic [N-1:0] Bo,
    output logic [N-1:0] Held,
    output logic         Any
);
    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int RT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RT_W   = $clog2(RT_MAX + 1);

    typedef enum logic [1:0] {IDLE, PRESS, HOLD, REPEAT} state_t;

    for (genvar g = 0; g < N; g++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic [DB_W-1:0]        r_dbCnt;
        logic                   r_held;
        logic                   w_synced;
        state_t                 r_state;
        state_t                 w_stateNext;
        logic [RT_W-1:0]        r_timer;
        logic [RT_W-1:0]        w_timerNext;
        logic [RT_W-1:0]        w_timerInc;
        logic                   r_bo;
        logic                   w_boNext;

        assign w_synced = r_sync[SYNC_STAGES-1];

        // Held only flips after DEBOUNCE consecutive disagreeing samples.
        always_ff @(posedge Clk) begin
            if (!ResetN) begin
                r_sync  <= '0;
                r_dbCnt <= '0;
                r_held  <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], Bi[g]};
                if (w_synced == r_held) begin
                    r_dbCnt <= '0;
                end else if (r_dbCnt >= DB_W'(DEBOUNCE - 1)) begin
                    r_dbCnt <= '0;
                    r_held  <= ~r_held;
                end else begin
                    r_dbCnt <= r_dbCnt + DB_W'(1);
                end
            end
        end

        always_ff @(posedge Clk) begin
            if (!ResetN) begin
                r_state <= IDLE;
                r_timer <= '0;
                r_bo    <= 1'b0;
            end else begin
                r_state <= w_stateNext;
                r_timer <= w_timerNext;
                r_bo    <= w_boNext;
            end
        end

        assign w_timerInc = (r_timer >= RT_W'(RT_MAX)) ? r_timer : r_timer + RT_W'(1);

        // The !r_bo guards keep at least one low cycle between pulses.
        always_comb begin
            w_stateNext = r_state;
            w_timerNext = r_timer;
            w_boNext    = 1'b0;
            if (!r_held) begin
                w_stateNext = IDLE;
                w_timerNext = '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        w_stateNext = PRESS;
                        w_timerNext = '0;
                        w_boNext    = 1'b1;
                    end
                    PRESS: begin
                        w_stateNext = HOLD;
                        w_timerNext = RepeatEn[g] ? w_timerInc : '0;
                    end
                    HOLD: begin
                        if (!RepeatEn[g]) begin
                            w_timerNext = '0;
                        end else if (w_timerInc >= RT_W'(REPEAT_DELAY) && !r_bo) begin
                            w_stateNext = REPEAT;
                            w_timerNext = '0;
                            w_boNext    = 1'b1;
                        end else begin
                            w_timerNext = w_timerInc;
                        end
                    end
                    REPEAT: begin
                        if (!RepeatEn[g]) begin
                            w_stateNext = HOLD;
                            w_timerNext = '0;
                        end else if (w_timerInc >= RT_W'(REPEAT_RATE) && !r_bo) begin
                            w_timerNext = '0;
                            w_boNext    = 1'b1;
                        end else begin
                            w_timerNext = w_timerInc;
                        end
                    end
                    default: begin
                        w_stateNext = IDLE;
                        w_timerNext = '0;
                    end
                endcase
            end
        end

        assign Bo[g]   = r_bo;
        assign Held[g] = r_held;
    end

    assign Any = |Bo;

endmodule

// File: tb/tb_button_sync_bank.sv
// Testbench for button_sync_bank: directed scenarios plus random bouncing
// buttons, compared each cycle against a deadline-based reference model.
module tb_button_sync_bank;
    localparam int N     = 4;
    localparam int SS    = 2;
    localparam int DEB   = 4;
    localparam int RDLY  = 16;
    localparam int RRATE = 8;
    localparam int MAXC  = 4000;

    logic         Clk;
    logic         ResetN;
    logic [N-1:0] Bi;
    logic [N-1:0] RepeatEn;
    logic [N-1:0] Bo;
    logic [N-1:0] Held;
    logic         Any;

    button_sync_bank #(
        .N(N), .SYNC_STAGES(SS), .DEBOUNCE(DEB),
        .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
    ) dut (
        .Clk(Clk), .ResetN(ResetN), .Bi(Bi), .RepeatEn(RepeatEn),
        .Bo(Bo), .Held(Held), .Any(Any)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int vectors     = 0;
    int miscompares = 0;
    int t           = 0;
    int lastReset   = 0;
    int segStart    = 0;
    int watchCh     = 0;
    int pulseEdges[$];
    int anyEdges[$];

    logic [N-1:0] biHist [MAXC];
    logic [N-1:0] mHeld  = '0;
    logic [N-1:0] mBo    = '0;
    logic [N-1:0] mActive = '0;
    logic         mAny   = 1'b0;
    int           due [N];

    // Synchronised level seen at edge e is the raw sample taken SS edges earlier.
    function automatic logic syncedAt(int e, int ch);
        if (e - SS > lastReset) return biHist[e - SS][ch];
        return 1'b0;
    endfunction

    // Held flips when the last DEB synchronised samples all disagree with it;
    // pulses fire on press and then at fixed deadlines while repeat is enabled.
    task automatic modelEdge(input logic [N-1:0] bi, input logic [N-1:0] rep, input logic rstn);
        logic heldPrev;
        logic allDiffer;
        biHist[t] = bi;
        if (!rstn) begin
            lastReset = t;
            mHeld     = '0;
            mBo       = '0;
            mActive   = '0;
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                heldPrev = mHeld[ch];
                if (!heldPrev) begin
                    mActive[ch] = 1'b0;
                    mBo[ch]     = 1'b0;
                end else if (!mActive[ch]) begin
                    mActive[ch] = 1'b1;
                    mBo[ch]     = 1'b1;
                    due[ch]     = t + RDLY;
                end else if (!rep[ch]) begin
                    mBo[ch] = 1'b0;
                    due[ch] = t + RDLY;
                end else if (t == due[ch]) begin
                    mBo[ch] = 1'b1;
                    due[ch] = t + RRATE;
                end else begin
                    mBo[ch] = 1'b0;
                end
                allDiffer = 1'b1;
                for (int i = 0; i < DEB; i++) begin
                    if (t - i <= lastReset || syncedAt(t - i, ch) == heldPrev) allDiffer = 1'b0;
                end
                if (allDiffer) mHeld[ch] = ~heldPrev;
            end
        end
        mAny = |mBo;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s edge=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] bi, input logic [N-1:0] rep, input logic rstn);
        Bi       = bi;
        RepeatEn = rep;
        ResetN   = rstn;
        @(posedge Clk);
        t++;
        modelEdge(bi, rep, rstn);
        #1;
        checkOutput("Bo", Bo, mBo);
        checkOutput("Held", Held, mHeld);
        checkOutput("Any", Any, mAny);
        if (Bo[watchCh] === 1'b1) pulseEdges.push_back(t - segStart);
        if (Any === 1'b1) anyEdges.push_back(t - segStart);
    endtask

    task automatic startSegment(input int ch);
        watchCh  = ch;
        segStart = t;
        pulseEdges.delete();
        anyEdges.delete();
    endtask

    initial begin
        int           expRep [7] = '{7, 23, 31, 39, 47, 55, 63};
        logic [9:0]   bounce = 10'b1111101101;
        logic [N-1:0] biR;
        logic [N-1:0] repR;
        logic         lvl [N];
        int           dur [N];
        int           bnc [N];
        int           idx;

        for (int ch = 0; ch < N; ch++) due[ch] = 0;

        $display("[TB] reset");
        repeat (3) applyStimulus('0, '0, 1'b0);
        repeat (2) applyStimulus('0, '0, 1'b1);

        $display("[TB] single press, no repeat");
        startSegment(0);
        repeat (40) applyStimulus(4'b0001, 4'b0000, 1'b1);
        repeat (12) applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("press_count", pulseEdges.size(), 1);
        if (pulseEdges.size() > 0) checkOutput("press_edge", pulseEdges[0], 7);

        $display("[TB] short glitch");
        startSegment(1);
        repeat (3)  applyStimulus(4'b0010, 4'b0000, 1'b1);
        repeat (10) applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("glitch_count", pulseEdges.size(), 0);

        $display("[TB] auto-repeat");
        startSegment(2);
        repeat (60) applyStimulus(4'b0100, 4'b0100, 1'b1);
        repeat (20) applyStimulus(4'b0000, 4'b0100, 1'b1);
        checkOutput("repeat_count", pulseEdges.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < pulseEdges.size()) checkOutput("repeat_edge", pulseEdges[i], expRep[i]);
        end

        $display("[TB] simultaneous channels");
        startSegment(3);
        repeat (20) applyStimulus(4'b1001, 4'b0000, 1'b1);
        repeat (12) applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("simul_count", pulseEdges.size(), 1);
        checkOutput("any_count", anyEdges.size(), 1);
        if (anyEdges.size() > 0) checkOutput("any_edge", anyEdges[0], 7);

        $display("[TB] reset mid-press");
        startSegment(0);
        repeat (9)  applyStimulus(4'b0001, 4'b0000, 1'b1);
        repeat (2)  applyStimulus(4'b0001, 4'b0000, 1'b0);
        startSegment(0);
        repeat (20) applyStimulus(4'b0001, 4'b0000, 1'b1);
        repeat (12) applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("rst_count", pulseEdges.size(), 1);
        if (pulseEdges.size() > 0) checkOutput("rst_edge", pulseEdges[0], 7);

        $display("[TB] bounce pattern");
        startSegment(1);
        for (int i = 9; i >= 0; i--) applyStimulus({2'b00, bounce[i], 1'b0}, 4'b0000, 1'b1);
        repeat (10) applyStimulus(4'b0010, 4'b0000, 1'b1);
        repeat (12) applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("bounce_count", pulseEdges.size(), 1);

        $display("[TB] random bouncing buttons");
        repR = 4'($urandom);
        for (int ch = 0; ch < N; ch++) begin
            lvl[ch] = 1'b0;
            dur[ch] = $urandom_range(40, 5);
            bnc[ch] = 0;
        end
        for (int c = 0; c < 700; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (dur[ch] == 0) begin
                    lvl[ch] = ~lvl[ch];
                    dur[ch] = $urandom_range(60, 3);
                    bnc[ch] = $urandom_range(6, 0);
                end else begin
                    dur[ch]--;
                end
                biR[ch] = lvl[ch] ^ (bnc[ch] > 0 && $urandom_range(2, 0) == 0);
                if (bnc[ch] > 0) bnc[ch]--;
            end
            if ($urandom_range(39, 0) == 0) begin
                idx = $urandom_range(N - 1, 0);
                repR[idx] = ~repR[idx];
            end
            applyStimulus(biR, repR, (c == 350 || c == 351) ? 1'b0 : 1'b1);
        end
        repeat (15) applyStimulus('0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
